// File: rtl/mont_pkg.sv
// Shared types and constants for the radix-4 Montgomery sequencer.
package mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOOP,
        ST_RESOLVE,
        ST_SUB,
        ST_DONE
    } state_e;

    localparam int         CHUNKS     = 6;
    localparam logic [3:0] PHASE_IDLE = 4'd8;
    localparam logic [3:0] PHASE_LAST = 4'(CHUNKS - 1);

endpackage

// File: rtl/mont_qdigit.sv
// Radix-4 Montgomery quotient digit: q = -(c + d*b) * m mod 4, using M^-1 = M (mod 4) for odd M.
module mont_qdigit (
    input  logic [1:0] c_in,
    input  logic [1:0] d,
    input  logic [1:0] b_low,
    input  logic [1:0] m_low,
    output logic [1:0] q
);

    logic [1:0] t;
    logic [1:0] tm;

    always_comb begin
        t  = c_in + d * b_low;
        tm = t * m_low;
        q  = 2'd0 - tm;
    end

endmodule

// File: rtl/mont_ctrl.sv
// Sequencer driving the carry-save Montgomery adder through one radix-4 multiplication:
// clear, digit loop, chunk resolution, then subtraction passes until the adder reports carry.
module mont_ctrl
    import mont_pkg::*;
#(
    parameter int ITERATIONS     = 256,
    parameter int MAX_SUB_PASSES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [2*ITERATIONS-1:0]   a_in,
    input  logic [1:0]                m_low,
    input  logic [1:0]                b_low,
    input  logic                      c_zero,
    input  logic                      c_one,
    input  logic                      sub_done,
    output logic                      adder_rstn,
    output logic [1:0]                b_sel,
    output logic [1:0]                m_sel,
    output logic                      c_doubleshift,
    output logic                      enable_c,
    output logic                      subtract,
    output logic [3:0]                phase,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int AW = 2 * ITERATIONS;
    localparam int DW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int PW = (MAX_SUB_PASSES > 1) ? $clog2(MAX_SUB_PASSES) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(ITERATIONS - 1);
    localparam logic [PW-1:0] LAST_PASS  = PW'(MAX_SUB_PASSES - 1);

    state_e          state_q, state_d;
    logic [3:0]      phase_q, phase_d;
    logic [DW-1:0]   digit_q, digit_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic [AW-1:0]   a_q, a_d;
    logic            error_q, error_d;
    logic            adder_rstn_q, adder_rstn_d;
    logic            c_doubleshift_q, c_doubleshift_d;
    logic            subtract_q, subtract_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      q_digit;

    mont_qdigit u_qdigit (
        .c_in  ({c_one, c_zero}),
        .d     (a_q[1:0]),
        .b_low (b_low),
        .m_low (m_low),
        .q     (q_digit)
    );

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        pass_d  = pass_q;
        a_d     = a_q;
        error_d = error_q;
        phase_d = PHASE_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    digit_d = '0;
                    pass_d  = '0;
                    error_d = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_LOOP;
            ST_LOOP: begin
                a_d     = {2'b00, a_q[AW-1:2]};
                digit_d = digit_q + 1'b1;
                if (digit_q == LAST_DIGIT) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                if (phase_q == PHASE_LAST) state_d = ST_SUB;
            end
            ST_SUB: begin
                // The adder's carry is only meaningful once the last chunk has been resolved.
                if (phase_q == PHASE_LAST) begin
                    if (sub_done) begin
                        state_d = ST_DONE;
                    end else if (pass_q != LAST_PASS) begin
                        pass_d = pass_q + 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Phase restarts at 0 on entry to RESOLVE/SUB and at the start of every new pass.
        if (state_d == ST_RESOLVE || state_d == ST_SUB) begin
            if (state_d != state_q || phase_q == PHASE_LAST) phase_d = 4'd0;
            else                                            phase_d = phase_q + 4'd1;
        end

        adder_rstn_d    = (state_d != ST_CLEAR);
        c_doubleshift_d = (state_d == ST_LOOP);
        subtract_d      = (state_d == ST_SUB);
        busy_d          = (state_d != ST_IDLE);
        done_d          = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            phase_q         <= PHASE_IDLE;
            digit_q         <= '0;
            pass_q          <= '0;
            error_q         <= 1'b0;
            adder_rstn_q    <= 1'b1;
            c_doubleshift_q <= 1'b0;
            subtract_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            digit_q         <= digit_d;
            pass_q          <= pass_d;
            error_q         <= error_d;
            adder_rstn_q    <= adder_rstn_d;
            c_doubleshift_q <= c_doubleshift_d;
            subtract_q      <= subtract_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
    end

    always_comb begin
        b_sel = 2'd0;
        m_sel = 2'd0;
        if (state_q == ST_LOOP) begin
            b_sel = a_q[1:0];
            m_sel = q_digit;
        end
    end

    assign adder_rstn    = adder_rstn_q;
    assign c_doubleshift = c_doubleshift_q;
    assign enable_c      = 1'b0;
    assign subtract      = subtract_q;
    assign phase         = phase_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_mont_ctrl.sv
// Directed bench for mont_ctrl: reset, digit/quotient outputs, phase sequencing and pass/error handling.
module tb_mont_ctrl;

    localparam int IT = 256;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [511:0]  a_in;
    logic [1:0]    m_low, b_low;
    logic          c_zero, c_one, sub_done;
    logic          adder_rstn, c_doubleshift, enable_c, subtract, busy, done, error;
    logic [1:0]    b_sel, m_sel;
    logic [3:0]    phase;

    logic [1:0]    qc, qd, qb, qm, qq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [3:0] ph_tr  [0:11];
    logic       sub_tr [0:11];

    always #5 clk = ~clk;

    mont_ctrl #(.ITERATIONS(IT), .MAX_SUB_PASSES(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .a_in(a_in),
        .m_low(m_low), .b_low(b_low), .c_zero(c_zero), .c_one(c_one),
        .sub_done(sub_done), .adder_rstn(adder_rstn), .b_sel(b_sel),
        .m_sel(m_sel), .c_doubleshift(c_doubleshift), .enable_c(enable_c),
        .subtract(subtract), .phase(phase), .busy(busy), .done(done),
        .error(error)
    );

    mont_qdigit u_qd (.c_in(qc), .d(qd), .b_low(qb), .m_low(qm), .q(qq));

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [511:0] a);
        a_in  = a;
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    // mode 0: sub_done always 1; mode 1: 0 at the first three pass ends; mode 2: always 0 plus a stray start.
    task automatic run_to_done(input int mode, output int dcyc, output logic derr);
        dcyc = -1;
        derr = 1'bx;
        while (cyc < 400) begin
            case (mode)
                0:       sub_done = 1'b1;
                1:       sub_done = !(cyc == 269 || cyc == 275 || cyc == 281);
                default: sub_done = 1'b0;
            endcase
            start = (mode == 2 && cyc == 100);
            if (cyc >= 258 && cyc <= 269) begin
                ph_tr[cyc-258]  = phase;
                sub_tr[cyc-258] = subtract;
            end
            if (done === 1'b1) begin
                dcyc = cyc;
                derr = error;
                start = 1'b0;
                return;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done by cycle %0d, expected done", cyc);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({adder_rstn, b_sel, m_sel, c_doubleshift, enable_c, subtract, busy, done, error, phase}
            !== {1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL reset_outputs: got rstn=%b b=%0d m=%0d ds=%b en=%b sub=%b busy=%b done=%b err=%b ph=%0d, expected 1 0 0 0 0 0 0 0 0 8",
                     adder_rstn, b_sel, m_sel, c_doubleshift, enable_c, subtract, busy, done, error, phase);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || phase !== 4'd8) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b phase=%0d, expected busy=0 phase=8", busy, phase);
        end
    endtask

    task automatic test_digit_a3();
        int dcyc;
        logic derr;
        int bad;
        c_zero = 1'b0; c_one = 1'b0; b_low = 2'd1; m_low = 2'd3; sub_done = 1'b1;
        do_start(512'h3);
        checks++;
        if (adder_rstn !== 1'b0 || busy !== 1'b1 || b_sel !== 2'd0) begin
            errors++;
            $display("FAIL clear_cycle: got rstn=%b busy=%b b_sel=%0d, expected 0 1 0", adder_rstn, busy, b_sel);
        end
        tick();
        checks++;
        if (b_sel !== 2'd3 || m_sel !== 2'd3 || c_doubleshift !== 1'b1 || adder_rstn !== 1'b1) begin
            errors++;
            $display("FAIL first_digit: got b_sel=%0d m_sel=%0d ds=%b rstn=%b, expected 3 3 1 1", b_sel, m_sel, c_doubleshift, adder_rstn);
        end
        bad = 0;
        for (int i = 3; i <= 257; i++) begin
            tick();
            if (b_sel !== 2'd0 || m_sel !== 2'd0 || c_doubleshift !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL loop_zero_digits: got %0d bad cycles in 3..257, expected 0", bad);
        end
        tick();
        checks++;
        if (c_doubleshift !== 1'b0 || b_sel !== 2'd0 || phase !== 4'd0) begin
            errors++;
            $display("FAIL loop_exit: got ds=%b b_sel=%0d phase=%0d at cycle 258, expected 0 0 0", c_doubleshift, b_sel, phase);
        end
        run_to_done(0, dcyc, derr);
        tick();
    endtask

    task automatic test_digit_pattern();
        int dcyc;
        logic derr;
        logic [1:0] exp_b [0:3];
        logic [1:0] exp_m [0:3];
        exp_b[0] = 2'd3; exp_b[1] = 2'd2; exp_b[2] = 2'd1; exp_b[3] = 2'd0;
        exp_m[0] = 2'd2; exp_m[1] = 2'd1; exp_m[2] = 2'd0; exp_m[3] = 2'd3;
        c_zero = 1'b1; c_one = 1'b0; b_low = 2'd3; m_low = 2'd1; sub_done = 1'b1;
        do_start(512'h1B);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (b_sel !== exp_b[k] || m_sel !== exp_m[k]) begin
                errors++;
                $display("FAIL digit_pattern_%0d: got b_sel=%0d m_sel=%0d, expected %0d %0d", k, b_sel, m_sel, exp_b[k], exp_m[k]);
            end
        end
        run_to_done(0, dcyc, derr);
        tick();
    endtask

    task automatic test_reset_mid_loop();
        do_start(512'hFFFF_FFFF);
        while (cyc < 102) tick();
        checks++;
        if (c_doubleshift !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_loop_state: got ds=%b busy=%b, expected 1 1", c_doubleshift, busy);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if ({adder_rstn, b_sel, m_sel, c_doubleshift, enable_c, subtract, busy, done, error, phase}
            !== {1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL mid_loop_reset: got rstn=%b b=%0d m=%0d ds=%b en=%b sub=%b busy=%b done=%b err=%b ph=%0d, expected 1 0 0 0 0 0 0 0 0 8",
                     adder_rstn, b_sel, m_sel, c_doubleshift, enable_c, subtract, busy, done, error, phase);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stay_idle_after_reset: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_qdigit_exhaustive();
        int bad;
        int t;
        logic [6:0] v;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            v  = 7'(i);
            qc = v[1:0];
            qd = v[3:2];
            qb = v[5:4];
            qm = {v[6], 1'b1};
            #1;
            t = (int'(qc) + int'(qd) * int'(qb)) % 4;
            checks++;
            if (((t + int'(qq) * int'(qm)) % 4) != 0) begin
                errors++;
                bad++;
                $display("FAIL qdigit_%0d: got q=%0d for c=%0d d=%0d b=%0d m=%0d, expected (t+q*m)%%4=0", i, qq, qc, qd, qb, qm);
            end
        end
    endtask

    task automatic test_single_pass();
        int dcyc;
        logic derr;
        do_start(512'h1234_5678);
        run_to_done(0, dcyc, derr);
        checks++;
        if (dcyc !== 270 || derr !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pass_done: got cycle=%0d error=%b busy=%b, expected 270 0 1", dcyc, derr, busy);
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (ph_tr[k] !== 4'(k % 6) || sub_tr[k] !== (k >= 6)) begin
                errors++;
                $display("FAIL phase_seq_%0d: got phase=%0d sub=%b, expected %0d %b", k, ph_tr[k], sub_tr[k], k % 6, (k >= 6));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || phase !== 4'd8 || adder_rstn !== 1'b1) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b done=%b phase=%0d rstn=%b, expected 0 0 8 1", busy, done, phase, adder_rstn);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_late: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_three_failed_passes();
        int dcyc;
        logic derr;
        do_start(512'h5);
        run_to_done(1, dcyc, derr);
        checks++;
        if (dcyc !== 288 || derr !== 1'b0) begin
            errors++;
            $display("FAIL four_pass_done: got cycle=%0d error=%b, expected 288 0", dcyc, derr);
        end
        tick();
    endtask

    task automatic test_error_sticky();
        int dcyc;
        logic derr;
        do_start(512'h9);
        run_to_done(2, dcyc, derr);
        checks++;
        if (dcyc !== 288 || derr !== 1'b1) begin
            errors++;
            $display("FAIL error_done: got cycle=%0d error=%b, expected 288 1", dcyc, derr);
        end
        tick();
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky_idle: got error=%b busy=%b, expected 1 0", error, busy);
        end
        do_start(512'h9);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL error_clear_on_start: got error=%b busy=%b, expected 0 1", error, busy);
        end
        run_to_done(0, dcyc, derr);
        checks++;
        if (dcyc !== 270 || derr !== 1'b0) begin
            errors++;
            $display("FAIL rerun_done: got cycle=%0d error=%b, expected 270 0", dcyc, derr);
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; a_in = '0; m_low = 2'd1; b_low = 2'd0;
        c_zero = 1'b0; c_one = 1'b0; sub_done = 1'b0;
        qc = 2'd0; qd = 2'd0; qb = 2'd0; qm = 2'd1;
        test_reset();
        test_digit_a3();
        test_digit_pattern();
        test_reset_mid_loop();
        test_qdigit_exhaustive();
        test_single_pass();
        test_three_failed_passes();
        test_error_sticky();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
